// File: rtl/apb_led_sequencer.sv
// apb_led_sequencer: APB slave holding a 4-entry LED pattern table.
// A prescaled tick steps through the table in loop or one-shot mode and
// drives the two-bit ledOut pins.
module apb_led_sequencer #(
    parameter int ADDRWIDTH = 12
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 PSEL,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [31:0]          PWDATA,
    input  logic [3:0]           ECOREVNUM,
    output logic [31:0]          PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic [1:0]           ledOut
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Word addresses (byte offset >> 2)
    localparam logic [ADDRWIDTH-3:0] W_CTRL     = (ADDRWIDTH-2)'(8'h00);
    localparam logic [ADDRWIDTH-3:0] W_PRESCALE = (ADDRWIDTH-2)'(8'h01);
    localparam logic [ADDRWIDTH-3:0] W_LENGTH   = (ADDRWIDTH-2)'(8'h02);
    localparam logic [ADDRWIDTH-3:0] W_STATUS   = (ADDRWIDTH-2)'(8'h03);
    localparam logic [ADDRWIDTH-3:0] W_PAT0     = (ADDRWIDTH-2)'(8'h04);
    localparam logic [ADDRWIDTH-3:0] W_PAT1     = (ADDRWIDTH-2)'(8'h05);
    localparam logic [ADDRWIDTH-3:0] W_PAT2     = (ADDRWIDTH-2)'(8'h06);
    localparam logic [ADDRWIDTH-3:0] W_PAT3     = (ADDRWIDTH-2)'(8'h07);
    localparam logic [ADDRWIDTH-3:0] W_ID       = '1;

    logic                 w_wr;
    logic                 w_rd;
    logic                 w_wr_ctrl;
    logic [ADDRWIDTH-3:0] w_waddr;
    logic [1:0]           w_pat_idx;
    logic                 w_tick;
    logic                 w_hold_done;
    logic                 w_unused_bits;

    logic        r_en;
    logic        r_oneshot;
    logic [23:0] r_prescale;
    logic [1:0]  r_length;
    logic [1:0]  r_pat_led  [0:3];
    logic [7:0]  r_pat_hold [0:3];
    state_t      r_state;
    logic [1:0]  r_step;
    logic [23:0] r_pcnt;
    logic [7:0]  r_hcnt;

    // Registers commit at the end of the setup phase
    assign w_wr        = PSEL & ~PENABLE & PWRITE;
    assign w_rd        = PSEL & ~PWRITE;
    assign w_waddr     = PADDR[ADDRWIDTH-1:2];
    assign w_pat_idx   = w_waddr[1:0];
    assign w_wr_ctrl   = w_wr && (w_waddr == W_CTRL);
    assign w_tick      = (r_pcnt >= r_prescale);
    assign w_hold_done = w_tick && (r_hcnt >= r_pat_hold[r_step]);

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    // Bits of the bus that no register uses
    assign w_unused_bits = &{1'b0, PWDATA[31:24], PADDR[1:0]};

    // Configuration register writes
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_en       <= 1'b0;
            r_oneshot  <= 1'b0;
            r_prescale <= 24'd0;
            r_length   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_pat_led[i]  <= 2'd0;
                r_pat_hold[i] <= 8'd0;
            end
        end else if (w_wr) begin
            case (w_waddr)
                W_CTRL: begin
                    r_en      <= PWDATA[0];
                    r_oneshot <= PWDATA[1];
                end
                W_PRESCALE: r_prescale <= PWDATA[23:0];
                W_LENGTH:   r_length   <= PWDATA[1:0];
                W_PAT0, W_PAT1, W_PAT2, W_PAT3: begin
                    r_pat_led[w_pat_idx]  <= PWDATA[1:0];
                    r_pat_hold[w_pat_idx] <= PWDATA[15:8];
                end
                default: ;
            endcase
        end
    end

    // Sequencer state machine: step, prescale and hold counters
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
            r_step  <= 2'd0;
            r_pcnt  <= 24'd0;
            r_hcnt  <= 8'd0;
        end else if (w_wr_ctrl && !PWDATA[0]) begin
            // EN=0 wins over RESTART
            r_state <= ST_IDLE;
            r_step  <= 2'd0;
            r_pcnt  <= 24'd0;
            r_hcnt  <= 8'd0;
        end else if (w_wr_ctrl && (PWDATA[2] || (r_state == ST_IDLE))) begin
            r_state <= ST_RUN;
            r_step  <= 2'd0;
            r_pcnt  <= 24'd0;
            r_hcnt  <= 8'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_tick) begin
                        r_pcnt <= 24'd0;
                        if (w_hold_done) begin
                            r_hcnt <= 8'd0;
                            if (r_step < r_length) begin
                                r_step <= r_step + 2'd1;
                            end else if (!r_oneshot) begin
                                r_step <= 2'd0;
                            end else begin
                                r_state <= ST_DONE;
                            end
                        end else begin
                            r_hcnt <= r_hcnt + 8'd1;
                        end
                    end else begin
                        r_pcnt <= r_pcnt + 24'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // LED drive follows the pattern table directly so PAT writes show at once
    always_comb begin
        if (r_state == ST_IDLE) begin
            ledOut = 2'b00;
        end else begin
            ledOut = r_pat_led[r_step];
        end
    end

    // Combinational read mux
    always_comb begin
        PRDATA = 32'h0;
        if (w_rd) begin
            case (w_waddr)
                W_CTRL:     PRDATA = {30'h0, r_oneshot, r_en};
                W_PRESCALE: PRDATA = {8'h0, r_prescale};
                W_LENGTH:   PRDATA = {30'h0, r_length};
                W_STATUS:   PRDATA = {26'h0, (r_state == ST_DONE), (r_state == ST_RUN),
                                      2'b00, r_step};
                W_PAT0, W_PAT1, W_PAT2, W_PAT3:
                            PRDATA = {16'h0, r_pat_hold[w_pat_idx], 6'h0,
                                      r_pat_led[w_pat_idx]};
                W_ID:       PRDATA = {24'h0, 4'h1, ECOREVNUM};
                default:    PRDATA = 32'h0;
            endcase
        end else begin
            PRDATA = 32'h0;
        end
    end

endmodule

// File: tb/tb_apb_led_sequencer.sv
// Testbench for apb_led_sequencer: scenario tasks with a queue scoreboard.
module tb_apb_led_sequencer;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL;
    logic [11:0] PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  ECOREVNUM;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [1:0]  ledOut;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    localparam logic [11:0] A_CTRL = 12'h000, A_PRESCALE = 12'h004, A_LENGTH = 12'h008,
                            A_STATUS = 12'h00C, A_PAT0 = 12'h010, A_PAT1 = 12'h014,
                            A_PAT2 = 12'h018, A_PAT3 = 12'h01C, A_BAD = 12'h020,
                            A_ID = 12'hFFC;

    apb_led_sequencer #(.ADDRWIDTH(12)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .ECOREVNUM(ECOREVNUM), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .ledOut(ledOut)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Write transfer; led_next is ledOut in the cycle right after the write edge
    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data,
                             output logic [1:0] led_next);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(negedge PCLK);
        led_next = ledOut;
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] addr, output logic [31:0] data);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        #1 data = PRDATA;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] addrs [10];
        logic [31:0] rd, e;
        addrs = '{A_CTRL, A_PRESCALE, A_LENGTH, A_STATUS, A_PAT0, A_PAT1,
                  A_PAT2, A_PAT3, A_BAD, A_ID};
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 12'h0; PWDATA = 32'h0; ECOREVNUM = 4'hE;
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        checks++;
        if (ledOut !== 2'b00 || PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
            failures++;
            $display("FAIL reset_pins led=%b ready=%b slverr=%b want 00/1/0",
                     ledOut, PREADY, PSLVERR);
        end
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back((addrs[i] == A_ID) ? 32'h0000_001E : 32'h0);
            apb_read(addrs[i], rd);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e) begin
                failures++;
                $display("FAIL reset_read addr=%h got=%h want=%h", addrs[i], rd, e);
            end
        end
    endtask

    task automatic test_loop();
        logic [1:0]  led;
        logic [31:0] rd, e;
        apb_write(A_PRESCALE, 32'd3, led);
        apb_write(A_LENGTH, 32'd1, led);
        apb_write(A_PAT0, 32'h0101, led);
        apb_write(A_PAT1, 32'h0002, led);
        for (int i = 1; i <= 20; i++)
            exp_q.push_back((i <= 8 || i > 12) ? 32'd1 : 32'd2);
        apb_write(A_CTRL, 32'h1, led);
        e = exp_q.pop_front();
        checks++;
        if ({30'h0, led} !== e) begin
            failures++;
            $display("FAIL loop_led cycle=1 got=%b want=%0d", led, e);
        end
        for (int i = 2; i <= 20; i++) begin
            e = exp_q.pop_front();
            checks++;
            if ({30'h0, ledOut} !== e) begin
                failures++;
                $display("FAIL loop_led cycle=%0d got=%b want=%0d", i, ledOut, e);
            end
            @(negedge PCLK);
        end
        exp_q.push_back(32'd1);
        apb_read(A_STATUS, rd);
        e = exp_q.pop_front();
        checks++;
        if ({31'h0, rd[4]} !== e) begin
            failures++;
            $display("FAIL loop_running status=%h want RUNNING=1", rd);
        end
        apb_write(A_CTRL, 32'h0, led);
    endtask

    task automatic test_oneshot();
        logic [1:0]  led;
        logic [31:0] rd, e;
        for (int i = 1; i <= 18; i++)
            exp_q.push_back((i <= 8) ? 32'd1 : 32'd2);
        apb_write(A_CTRL, 32'h3, led);
        e = exp_q.pop_front();
        checks++;
        if ({30'h0, led} !== e) begin
            failures++;
            $display("FAIL oneshot_led cycle=1 got=%b want=%0d", led, e);
        end
        for (int i = 2; i <= 18; i++) begin
            e = exp_q.pop_front();
            checks++;
            if ({30'h0, ledOut} !== e) begin
                failures++;
                $display("FAIL oneshot_led cycle=%0d got=%b want=%0d", i, ledOut, e);
            end
            @(negedge PCLK);
        end
        exp_q.push_back(32'h21);
        apb_read(A_STATUS, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin
            failures++;
            $display("FAIL oneshot_done_status got=%h want=%h", rd, e);
        end
        exp_q.push_back(32'd1);
        apb_write(A_CTRL, 32'h7, led);
        e = exp_q.pop_front();
        checks++;
        if ({30'h0, led} !== e) begin
            failures++;
            $display("FAIL restart_led got=%b want=%0d", led, e);
        end
        exp_q.push_back(32'h10);
        apb_read(A_STATUS, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin
            failures++;
            $display("FAIL restart_status got=%h want=%h", rd, e);
        end
        exp_q.push_back(32'h3);
        apb_read(A_CTRL, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin
            failures++;
            $display("FAIL restart_ctrl_read got=%h want=%h", rd, e);
        end
        apb_write(A_CTRL, 32'h0, led);
    endtask

    task automatic test_disable();
        logic [1:0]  led;
        logic [31:0] rd, e;
        apb_write(A_CTRL, 32'h1, led);
        repeat (3) @(negedge PCLK);
        exp_q.push_back(32'd0);
        apb_write(A_CTRL, 32'h0, led);
        e = exp_q.pop_front();
        checks++;
        if ({30'h0, led} !== e) begin
            failures++;
            $display("FAIL disable_led got=%b want=%0d", led, e);
        end
        exp_q.push_back(32'h0);
        apb_read(A_STATUS, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin
            failures++;
            $display("FAIL disable_status got=%h want=%h", rd, e);
        end
        exp_q.push_back(32'd0);
        apb_write(A_CTRL, 32'h4, led);
        repeat (3) @(negedge PCLK);
        e = exp_q.pop_front();
        checks++;
        if ({30'h0, ledOut} !== e || {30'h0, led} !== e) begin
            failures++;
            $display("FAIL restart_no_en_led got=%b/%b want=%0d", led, ledOut, e);
        end
        exp_q.push_back(32'h0);
        apb_read(A_STATUS, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin
            failures++;
            $display("FAIL restart_no_en_status got=%h want=%h", rd, e);
        end
        exp_q.push_back(32'h0);
        apb_read(A_CTRL, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin
            failures++;
            $display("FAIL restart_no_en_ctrl got=%h want=%h", rd, e);
        end
    endtask

    task automatic test_fast_and_length();
        logic [1:0]  led;
        logic [31:0] rd, e;
        int          waited;
        apb_write(A_PRESCALE, 32'd0, led);
        apb_write(A_LENGTH, 32'd3, led);
        apb_write(A_PAT0, 32'h0000, led);
        apb_write(A_PAT1, 32'h0001, led);
        apb_write(A_PAT2, 32'h0002, led);
        apb_write(A_PAT3, 32'h0003, led);
        for (int i = 1; i <= 8; i++) exp_q.push_back(32'((i - 1) % 4));
        apb_write(A_CTRL, 32'h1, led);
        e = exp_q.pop_front();
        checks++;
        if ({30'h0, led} !== e) begin
            failures++;
            $display("FAIL fast_led cycle=1 got=%b want=%0d", led, e);
        end
        for (int i = 2; i <= 8; i++) begin
            e = exp_q.pop_front();
            checks++;
            if ({30'h0, ledOut} !== e) begin
                failures++;
                $display("FAIL fast_led cycle=%0d got=%b want=%0d", i, ledOut, e);
            end
            @(negedge PCLK);
        end
        apb_write(A_CTRL, 32'h0, led);
        // Longer hold on step 2 so LENGTH can be rewritten while it is current
        apb_write(A_PAT2, 32'h0702, led);
        apb_write(A_CTRL, 32'h1, led);
        exp_q.push_back(32'h12);
        apb_read(A_STATUS, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin
            failures++;
            $display("FAIL step2_status got=%h want=%h", rd, e);
        end
        exp_q.push_back(32'd2);
        apb_write(A_LENGTH, 32'd0, led);
        e = exp_q.pop_front();
        checks++;
        if ({30'h0, led} !== e) begin
            failures++;
            $display("FAIL length_write_led got=%b want=%0d", led, e);
        end
        waited = 0;
        while (ledOut == 2'd2 && waited < 20) begin
            @(negedge PCLK);
            waited++;
        end
        exp_q.push_back(32'd0);
        e = exp_q.pop_front();
        checks++;
        if (waited >= 20 || {30'h0, ledOut} !== e) begin
            failures++;
            $display("FAIL length_shrink_wrap led=%b waited=%0d want led=%0d", ledOut, waited, e);
        end
        exp_q.push_back(32'h10);
        apb_read(A_STATUS, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin
            failures++;
            $display("FAIL length_shrink_status got=%h want=%h", rd, e);
        end
    endtask

    task automatic test_unmapped_and_reset();
        logic [11:0] addrs [10];
        logic [31:0] vals  [10];
        logic [1:0]  led;
        logic [31:0] rd, e;
        addrs = '{A_CTRL, A_PRESCALE, A_LENGTH, A_STATUS, A_PAT0, A_PAT1,
                  A_PAT2, A_PAT3, A_BAD, A_ID};
        vals  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0000, 32'h0001,
                  32'h0702, 32'h0003, 32'h0, 32'h0000_001E};
        apb_write(A_CTRL, 32'h0, led);
        apb_write(A_BAD, 32'hFFFF_FFFF, led);
        apb_write(A_ID, 32'hFFFF_FFFF, led);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(vals[i]);
            apb_read(addrs[i], rd);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e) begin
                failures++;
                $display("FAIL unmapped_write addr=%h got=%h want=%h", addrs[i], rd, e);
            end
        end
        apb_write(A_PAT0, 32'h0003, led);
        apb_write(A_CTRL, 32'h1, led);
        @(negedge PCLK);
        checks++;
        if (ledOut !== 2'd3) begin
            failures++;
            $display("FAIL pre_reset_led got=%b want=11", ledOut);
        end
        #2 PRESETn = 1'b0;
        #1;
        checks++;
        if (ledOut !== 2'b00) begin
            failures++;
            $display("FAIL async_reset_led got=%b want=00", ledOut);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back((addrs[i] == A_ID) ? 32'h0000_001E : 32'h0);
            apb_read(addrs[i], rd);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e) begin
                failures++;
                $display("FAIL post_reset_read addr=%h got=%h want=%h", addrs[i], rd, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loop();
        test_oneshot();
        test_disable();
        test_fast_and_length();
        test_unmapped_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_led_sequencer.md
Name: apb_led_sequencer

Overview:
APB slave that drives the board's two-bit LED output from a programmable pattern sequencer, replacing static software writes. It holds a 4-entry pattern table and steps through it on a prescaled tick, in loop or one-shot mode. It sits on the peripheral APB bus next to the other custom APB slaves and drives the ledOut pins.

Parameters:
ADDRWIDTH, 12, APB address width; decode uses PADDR[ADDRWIDTH-1:2].

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  APB select
PADDR  in  ADDRWIDTH  APB address
PENABLE  in  1  APB enable
PWRITE  in  1  APB write
PWDATA  in  32  APB write data
ECOREVNUM  in  4  ECO revision, reported in the ID register
PRDATA  out  32  APB read data
PREADY  out  1  tied 1
PSLVERR  out  1  tied 0
ledOut  out  2  LED drive

Behaviour:
- Interface: one clock PCLK; reset PRESETn is asynchronous, active-low.
- Write strobe is PSEL & ~PENABLE & PWRITE, so a register updates at the end of the setup cycle.
- Read data is combinational from PADDR while PSEL & ~PWRITE; otherwise 0.
- Unmapped reads return 0. Unmapped writes are ignored.
- Register map (byte offsets):
  - 0x000 CTRL (RW) [0] EN, [1] ONESHOT, [2] RESTART. RESTART is write-only and reads 0.
  - 0x004 PRESCALE (RW) [23:0].
  - 0x008 LENGTH (RW) [1:0]. Sequence length is LENGTH+1 steps.
  - 0x00C STATUS (RO) [1:0] current step, [4] RUNNING, [5] DONE.
  - 0x010/0x014/0x018/0x01C PATn (RW) [1:0] LED value, [15:8] HOLD.
  - 0xFFC ID (RO) {24'h0, 4'h1, ECOREVNUM}.
- Reset values: all registers 0, state IDLE, step 0, prescale and hold counters 0, ledOut 2'b00, PRDATA 0.
- State machine:
  - IDLE: ledOut = 2'b00; counters held at 0. A CTRL write with EN=1 moves to RUN on the next edge, with step=0 and counters=0.
  - RUN: ledOut = PAT[step][1:0], combinational, so a PAT write takes effect immediately.
    - Prescale counter increments each cycle. tick = (pcnt >= PRESCALE); on tick, pcnt returns to 0.
    - On tick, hold counter increments. When a tick occurs with hcnt >= PAT[step].HOLD, hcnt returns to 0 and the step ends.
    - At step end with step < LENGTH: step+1.
    - At step end with step >= LENGTH: step returns to 0 if ONESHOT=0; otherwise go to DONE.
  - DONE: ledOut holds the last step's value; counters stopped; STATUS.DONE=1.
- Step duration: (HOLD+1)*(PRESCALE+1) PCLK cycles. The first step starts the cycle after the enabling write.
- CTRL write with EN=0: go to IDLE next edge from any state, clear counters and step, clear DONE.
- RESTART=1 with EN=1: step=0, counters=0, DONE cleared, RUN next edge, from RUN or DONE; a write to an idle block starts it as normal.
- EN=0 together with RESTART=1: EN=0 wins, go to IDLE.
- Changing ONESHOT alone in RUN takes effect at the next wrap decision. Changing it in DONE has no effect until RESTART.
- STATUS.RUNNING = (state==RUN).
- Writes to PRESCALE, LENGTH or HOLD mid-run take effect immediately. The >= compares guarantee the current step ends within one tick when the new value is below the counter.
- Reset asserted mid-sequence returns everything to reset values immediately; ledOut goes to 2'b00 asynchronously.

Test Plan:
1. Reset, then read every register -> all 0; ID = 0x0000001E when ECOREVNUM=4'hE; ledOut=00; PREADY=1, PSLVERR=0.
2. PRESCALE=3, LENGTH=1, PAT0=0x0101, PAT1=0x0002, CTRL=0x1 -> ledOut=01 for 8 cycles, then 10 for 4 cycles, then 01 again (loop); STATUS.RUNNING=1.
3. Same setup with CTRL=0x3 -> after 12 cycles state DONE, ledOut stays 10, STATUS=0x21; a CTRL=0x7 write restarts with ledOut=01 and STATUS.DONE=0.
4. Mid-run CTRL=0x0 -> next cycle ledOut=00, STATUS=0. CTRL=0x4 (EN=0 plus RESTART) -> stays IDLE.
5. PRESCALE=0, all HOLD=0, LENGTH=3, PAT values 0/1/2/3 -> ledOut changes every cycle in the order 0,1,2,3,0. Writing LENGTH=0 while step=2 -> step returns to 0 at the next step end.
6. Writes to 0x020 and 0xFFC -> no register changes; reads of 0x020 return 0. PRESETn asserted mid-RUN -> ledOut=00 asynchronously and all registers are 0 after release.
